psram_xfer_arb: RTL and testbench

PSRAM_XFER_ARB -- requirements
Module: psram_xfer_arb

---
 rtl/psram_pkg.sv | 18 +
 rtl/psram_rr_arb2.sv | 32 +++
 rtl/psram_xfer_arb.sv | 153 +++++++++++++++
 tb/tb_psram_xfer_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types and width constants for the PSRAM transfer path.
// Used by the arbiter front-end and its round-robin picker.
package psram_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RECY_W = 8;

    localparam logic OWN_CFG = 1'b0;
    localparam logic OWN_BUS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-way round-robin picker; the favoured side flips only when a
// grant is actually accepted.
module psram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0: cfg wins a tie, 1: bus wins a tie
    logic pri;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pri ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            pri <= grant[0];
        end
    end

endmodule

// File: rtl/psram_xfer_arb.sv
// Arbitrates config and AXI-side requesters onto the single psram_core
// transfer port, with a programmable recovery gap after every transfer.
module psram_xfer_arb
    import psram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [RECY_W-1:0]       recy_i,

    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic                    cfg_rdwr_i,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr_i,
    input  logic [DATA_WIDTH-1:0]   cfg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cfg_wmask_i,

    input  logic                    bus_valid_i,
    output logic                    bus_ready_o,
    input  logic                    bus_rdwr_i,
    input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
    input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] bus_wmask_i,

    output logic                    cfg_rsp_valid_o,
    output logic                    bus_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,

    output logic                    xfer_valid_o,
    output logic                    xfer_rdwr_o,
    output logic [ADDR_WIDTH-1:0]   xfer_addr_o,
    output logic [DATA_WIDTH-1:0]   xfer_wdata_o,
    output logic [DATA_WIDTH/8-1:0] xfer_wmask_o,
    input  logic                    xfer_ready_i,
    input  logic [DATA_WIDTH-1:0]   xfer_rdata_i,

    output logic                    busy_o,
    output logic                    owner_o
);

    state_t            state;
    state_t            state_nxt;
    logic [RECY_W-1:0] cnt;
    logic [RECY_W-1:0] cnt_nxt;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic              done;

    assign req = {bus_valid_i, cfg_valid_i};

    // Grants are only offered from IDLE while enabled and out of reset
    assign accept = rst_n_i && en_i && (state == ST_IDLE) && (req != 2'b00);
    assign done   = (state == ST_BUSY) && xfer_ready_i;

    assign cfg_ready_o  = accept && grant[0];
    assign bus_ready_o  = accept && grant[1];
    assign xfer_valid_o = (state == ST_BUSY);
    assign busy_o       = (state != ST_IDLE);

    psram_rr_arb2 u_rr (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // recy_i is looked at only here, so later edits can't
                // stretch or cut an ongoing recovery
                if (xfer_ready_i) begin
                    if (recy_i != '0) begin
                        state_nxt = ST_RECOVER;
                        cnt_nxt   = recy_i;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RECOVER: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt <= 1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_o      <= OWN_CFG;
            xfer_rdwr_o  <= 1'b0;
            xfer_addr_o  <= '0;
            xfer_wdata_o <= '0;
            xfer_wmask_o <= '0;
        end else if (accept) begin
            owner_o <= grant[1];
            if (grant[1]) begin
                xfer_rdwr_o  <= bus_rdwr_i;
                xfer_addr_o  <= bus_addr_i;
                xfer_wdata_o <= bus_wdata_i;
                xfer_wmask_o <= bus_wmask_i;
            end else begin
                xfer_rdwr_o  <= cfg_rdwr_i;
                xfer_addr_o  <= cfg_addr_i;
                xfer_wdata_o <= cfg_wdata_i;
                xfer_wmask_o <= cfg_wmask_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_rsp_valid_o <= 1'b0;
            bus_rsp_valid_o <= 1'b0;
            rsp_rdata_o     <= '0;
        end else begin
            cfg_rsp_valid_o <= done && (owner_o == OWN_CFG);
            bus_rsp_valid_o <= done && (owner_o == OWN_BUS);
            if (done) begin
                rsp_rdata_o <= xfer_rdwr_o ? xfer_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Scoreboard bench for psram_xfer_arb with a small psram_core model.
module tb_psram_xfer_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  recy = 8'd0;
    logic        cfg_valid = 1'b0, cfg_ready, cfg_rdwr = 1'b0;
    logic [31:0] cfg_addr = '0, cfg_wdata = '0;
    logic [3:0]  cfg_wmask = '0;
    logic        bus_valid = 1'b0, bus_ready, bus_rdwr = 1'b0;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic [3:0]  bus_wmask = '0;
    logic        cfg_rsp_valid, bus_rsp_valid;
    logic [31:0] rsp_rdata;
    logic        xfer_valid, xfer_rdwr;
    logic [31:0] xfer_addr, xfer_wdata;
    logic [3:0]  xfer_wmask;
    logic        xfer_ready = 1'b0;
    logic [31:0] xfer_rdata = 32'h0BAD_F00D;
    logic        busy, owner;

    psram_xfer_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .recy_i(recy),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_rdwr_i(cfg_rdwr), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_wmask_i(cfg_wmask),
        .bus_valid_i(bus_valid), .bus_ready_o(bus_ready),
        .bus_rdwr_i(bus_rdwr), .bus_addr_i(bus_addr),
        .bus_wdata_i(bus_wdata), .bus_wmask_i(bus_wmask),
        .cfg_rsp_valid_o(cfg_rsp_valid), .bus_rsp_valid_o(bus_rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .xfer_valid_o(xfer_valid), .xfer_rdwr_o(xfer_rdwr),
        .xfer_addr_o(xfer_addr), .xfer_wdata_o(xfer_wdata),
        .xfer_wmask_o(xfer_wmask), .xfer_ready_i(xfer_ready),
        .xfer_rdata_i(xfer_rdata),
        .busy_o(busy), .owner_o(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d",
                     tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic        grant_log[$];
    int          grant_cyc[$];
    int          vstart_cyc[$];
    int          done_cyc[$];
    int          rsp_cyc[$];
    logic [31:0] core_rdata = 32'h0;
    int          core_lat = 2;

    // Grant watcher: records every accepted request and its expected response
    rsp_t w_e;
    logic w_rd;
    initial forever begin
        @(negedge clk); #2;
        check("rdy_rule",
              {cfg_ready & bus_ready, (cfg_ready | bus_ready) & ~en,
               cfg_ready & ~cfg_valid, bus_ready & ~bus_valid,
               (cfg_ready | bus_ready) & busy}, 5'b0);
        if (cfg_ready || bus_ready) begin
            w_e.owner = bus_ready;
            w_rd = bus_ready ? bus_rdwr : cfg_rdwr;
            w_e.data = w_rd ? core_rdata : 32'h0;
            sb.push_back(w_e);
            grant_log.push_back(w_e.owner);
            grant_cyc.push_back(cyc);
        end
    end

    // psram_core model: answers after core_lat cycles unless valid drops
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    bit          c_alive;
    initial forever begin
        @(negedge clk); #1;
        if (xfer_valid === 1'b1) begin
            c_addr = xfer_addr;
            c_wdata = xfer_wdata;
            c_alive = 1'b1;
            vstart_cyc.push_back(cyc);
            for (int i = 0; i < core_lat && c_alive; i++) begin
                @(negedge clk); #1;
                if (xfer_valid !== 1'b1) c_alive = 1'b0;
            end
            if (c_alive) begin
                check("hold_addr", xfer_addr, c_addr);
                check("hold_wdata", xfer_wdata, c_wdata);
                xfer_ready = 1'b1;
                xfer_rdata = core_rdata;
                done_cyc.push_back(cyc);
                @(negedge clk); #1;
                check("valid_drop", xfer_valid, 1'b0);
                xfer_ready = 1'b0;
                xfer_rdata = 32'h0BAD_F00D;
            end
        end
    end

    // Response monitor: pops the scoreboard on every completion pulse
    rsp_t m_e;
    initial forever begin
        @(negedge clk); #3;
        if (cfg_rsp_valid || bus_rsp_valid) begin
            rsp_cyc.push_back(cyc);
            check("rsp_both", cfg_rsp_valid & bus_rsp_valid, 1'b0);
            if (sb.size() == 0) begin
                check("rsp_unexp", cfg_rsp_valid | bus_rsp_valid, 1'b0);
            end else begin
                m_e = sb.pop_front();
                check("rsp_owner", bus_rsp_valid, m_e.owner);
                check("rsp_data", rsp_rdata, m_e.data);
            end
        end
    end

    task automatic wait_idle(input int lim);
        int k = 0;
        while ((busy || sb.size() != 0 || cfg_rsp_valid || bus_rsp_valid)
               && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", k < lim, 1'b1);
    endtask

    task automatic wait_grants(input int n, input int lim);
        int k = 0;
        while (grant_log.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("grant_wait", grant_log.size() >= n, 1'b1);
    endtask

    task automatic req_one(input bit side, input bit rd,
                           input logic [31:0] addr, input logic [31:0] wd);
        int k = 0;
        bit got = 1'b0;
        if (side) begin
            bus_valid = 1'b1; bus_rdwr = rd; bus_addr = addr;
            bus_wdata = wd; bus_wmask = 4'hF;
        end else begin
            cfg_valid = 1'b1; cfg_rdwr = rd; cfg_addr = addr;
            cfg_wdata = wd; cfg_wmask = 4'hF;
        end
        while (!got && k < 40) begin
            #2;
            got = side ? bus_ready : cfg_ready;
            @(negedge clk);
            k++;
        end
        cfg_valid = 1'b0;
        bus_valid = 1'b0;
        check("req_granted", got, 1'b1);
    endtask

    int n0, d0, v0, r0, idx;

    initial begin
        // Reset state
        #1;
        check("rst_xvalid", xfer_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_rsp", {cfg_rsp_valid, bus_rsp_valid}, 2'b0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_addr", xfer_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);

        // Single cfg write, no recovery
        core_lat = 3;
        req_one(1'b0, 1'b0, 32'h10, 32'hA5);
        check("w_xvalid", xfer_valid, 1'b1);
        check("w_addr", xfer_addr, 32'h10);
        check("w_wdata", xfer_wdata, 32'hA5);
        check("w_rdwr", xfer_rdwr, 1'b0);
        check("w_owner", owner, 1'b0);
        wait_idle(50);
        idx = grant_cyc.size() - 1;
        check("w_vstart", vstart_cyc[idx] - grant_cyc[idx], 1);
        check("w_rsp_lat", rsp_cyc[rsp_cyc.size()-1] - done_cyc[done_cyc.size()-1], 1);

        // Bus write leaves the tie-break favouring cfg
        core_lat = 1;
        req_one(1'b1, 1'b0, 32'h20, 32'h1234);
        wait_idle(50);
        check("bw_owner", owner, 1'b1);

        // Continuous contention over four transfers
        n0 = grant_log.size();
        cfg_valid = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h100;
        cfg_wdata = 32'h11; cfg_wmask = 4'h3;
        bus_valid = 1'b1; bus_rdwr = 1'b0; bus_addr = 32'h200;
        bus_wdata = 32'h22; bus_wmask = 4'hC;
        wait_grants(n0 + 4, 100);
        cfg_valid = 1'b0;
        bus_valid = 1'b0;
        wait_idle(50);
        if (grant_log.size() >= n0 + 4) begin
            check("rr_g0", grant_log[n0], 1'b0);
            check("rr_g1", grant_log[n0+1], 1'b1);
            check("rr_g2", grant_log[n0+2], 1'b0);
            check("rr_g3", grant_log[n0+3], 1'b1);
        end

        // Bus read returning data
        core_rdata = 32'hDEADBEEF;
        core_lat = 2;
        req_one(1'b1, 1'b1, 32'h40, 32'h0);
        wait_idle(50);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);

        // Back-to-back bus reads with recy=3, recy edited mid-recovery
        recy = 8'd3;
        n0 = grant_cyc.size();
        d0 = done_cyc.size();
        v0 = vstart_cyc.size();
        bus_valid = 1'b1; bus_rdwr = 1'b1; bus_addr = 32'h300;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_cyc.size() > d0 && cyc > done_cyc[d0]
                && cyc <= done_cyc[d0] + 3) begin
                check("rcv_busy", busy, 1'b1);
                check("rcv_xvalid", xfer_valid, 1'b0);
                recy = 8'd0;
            end
            if (grant_cyc.size() >= n0 + 2) break;
        end
        bus_valid = 1'b0;
        wait_idle(60);
        check("rcv_gap",
              (vstart_cyc.size() > v0 + 1 && done_cyc.size() > d0)
                ? vstart_cyc[v0+1] - done_cyc[d0] : -1, 5);

        // en dropped mid-BUSY
        core_lat = 4;
        n0 = grant_log.size();
        cfg_valid = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h500;
        bus_valid = 1'b1; bus_rdwr = 1'b0; bus_addr = 32'h600;
        wait_grants(n0 + 1, 40);
        en = 1'b0;
        wait_idle(50);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #2;
            check("en_off_rdy", {cfg_ready, bus_ready}, 2'b0);
        end
        check("en_off_cnt", grant_log.size(), n0 + 1);
        cfg_valid = 1'b0;
        bus_valid = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Reset mid-BUSY, then contention goes to cfg
        core_lat = 6;
        req_one(1'b1, 1'b0, 32'h700, 32'h77);
        req_one(1'b0, 1'b0, 32'h800, 32'h88);
        n0 = grant_log.size();
        r0 = rsp_cyc.size();
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_xvalid", xfer_valid, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_sb", sb.size(), 1);
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        check("ar_norsp", rsp_cyc.size(), r0);
        cfg_valid = 1'b1; cfg_rdwr = 1'b0; cfg_addr = 32'h900;
        bus_valid = 1'b1; bus_rdwr = 1'b0; bus_addr = 32'hA00;
        rst_n = 1'b1;
        wait_grants(n0 + 1, 20);
        cfg_valid = 1'b0;
        bus_valid = 1'b0;
        if (grant_log.size() > n0) check("ar_first", grant_log[n0], 1'b0);
        wait_idle(60);

        repeat (4) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
